// File: rtl/sigma_delta_pkg.sv
// Definitions shared between the sigma-delta ADC harness and its sample path:
// the decimator word width and the offset-binary to two's-complement conversion.
package sigma_delta_pkg;

  localparam int ADC_DATA_WIDTH = 18;

  // Flipping the MSB maps offset binary onto two's complement.
  // Widths up to 64 bits are supported.
  function automatic logic [63:0] offset_to_twos(input logic [63:0] sample, input int width);
    return sample ^ (64'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/sample_fifo_mem.sv
// Sample storage for the ADC FIFO: one synchronous write port and one
// asynchronous read port. The array has no reset.
module sample_fifo_mem #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adc_sample_fifo.sv
// Show-ahead FIFO between the ADC decimator and its consumer. When the FIFO is
// full, the newest sample is dropped and a sticky overflow flag is set.
module adc_sample_fifo
  import sigma_delta_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int DEPTH_LOG2 = 4,
  parameter bit SIGNED_OUT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level_q, level_next;
  logic                  out_valid_q, overflow_q;
  logic [DATA_WIDTH-1:0] wr_word, rd_data;
  logic                  full, push, pop, drop;

  // Handshake: a word moves to the consumer on any rising edge where
  // out_valid && out_ready. While out_valid is high and out_ready is low,
  // out_data is held. in_valid has no backpressure; when no slot is free,
  // the sample is dropped.
  assign full = (level_q == FULL_LEVEL);
  assign pop  = out_valid_q & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  assign wr_word = SIGNED_OUT ? DATA_WIDTH'(offset_to_twos(64'(in_data), DATA_WIDTH))
                              : in_data;

  always_comb begin
    level_next = level_q;
    case ({push, pop})
      2'b10:   level_next = level_q + 1'b1;
      2'b01:   level_next = level_q - 1'b1;
      default: level_next = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level_q     <= level_next;
      out_valid_q <= (level_next != '0);
      // When a drop and a clear coincide, the drop wins.
      if (drop)              overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  sample_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // The head entry is read combinationally. Gating it with out_valid forces zero
  // while reset is held and while the FIFO is empty.
  assign out_data  = out_valid_q ? rd_data : '0;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed test of adc_sample_fifo: one unsigned instance and one SIGNED_OUT instance.
module tb_adc_sample_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] in_data;
  logic        in_valid, out_ready, overflow_clr;
  logic [17:0] out_data;
  logic        out_valid, overflow;
  logic [4:0]  level;

  logic        in_valid_s, out_ready_s;
  logic [17:0] out_data_s;
  logic        out_valid_s, overflow_s;
  logic [4:0]  level_s;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  int cnt;
  logic do_pop;

  always #5 clk = ~clk;

  adc_sample_fifo dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  adc_sample_fifo #(.SIGNED_OUT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_s),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .level(level_s), .overflow(overflow_s), .overflow_clr(overflow_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input logic [17:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_data  = base + 18'(i);
      in_valid = 1'b1;
      exp_q.push_back(base + 18'(i));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_n(input string tag, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk(tag, {14'd0, out_data}, {14'd0, exp_q[0]});
      void'(exp_q.pop_front());
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    overflow_clr = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b0;
    #2;
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", overflow, 0);
    tick();
    rst_n = 1'b1;

    // Single push while the consumer stalls
    in_data = 18'h00001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 18'h00001);
    chk("first_level", level, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_level", level, 0);
    chk("pop_valid", out_valid, 0);

    // Fill to 16, then overflow with the 17th sample
    push_n(18'd1, 16);
    chk("full_level", level, 16);
    chk("full_ovf", overflow, 0);
    in_data = 18'd17; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("drop_level", level, 16);
    chk("drop_ovf", overflow, 1);
    chk("hold_data", out_data, 18'd1);
    in_data = 18'd18; in_valid = 1'b1; overflow_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("set_prio_ovf", overflow, 1);
    tick();
    overflow_clr = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("hold_valid", out_valid, 1);
    drain_n("drain1", 16);
    chk("drain1_level", level, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("empty_ready_level", level, 0);

    // Push and pop in the same cycle while full
    push_n(18'h100, 16);
    in_data = 18'h200; in_valid = 1'b1; out_ready = 1'b1;
    chk("pp_head", out_data, exp_q[0]);
    void'(exp_q.pop_front());
    exp_q.push_back(18'h200);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pp_level", level, 16);
    chk("pp_ovf", overflow, 0);
    drain_n("drain2", 16);
    chk("drain2_level", level, 0);

    // Random traffic with pointer wrap
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 18'($urandom_range(0, 262143));
      out_ready = 1'($urandom_range(0, 1));
      do_pop = (cnt > 0) && out_ready;
      if (do_pop) begin
        chk("rnd_data", out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (in_valid && (cnt < 16 || do_pop)) exp_q.push_back(in_data);
      cnt = exp_q.size();
      tick();
      chk("rnd_level", level, cnt);
      chk("rnd_valid", out_valid, (cnt > 0) ? 1 : 0);
    end
    in_valid = 1'b0;
    drain_n("rnd_drain", cnt);
    chk("rnd_end_level", level, 0);

    // Offset binary to two's complement conversion
    in_valid_s = 1'b1;
    in_data = 18'h20000; tick();
    in_data = 18'h3FFFF; tick();
    in_data = 18'h00000; tick();
    in_valid_s = 1'b0;
    chk("s_level", level_s, 3);
    out_ready_s = 1'b1;
    chk("s_data0", out_data_s, 18'h00000); tick();
    chk("s_data1", out_data_s, 18'h1FFFF); tick();
    chk("s_data2", out_data_s, 18'h20000); tick();
    out_ready_s = 1'b0;
    chk("s_empty", out_valid_s, 0);

    // Asynchronous reset with level 5 and overflow set
    push_n(18'h300, 16);
    in_data = 18'h3FF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain_n("pre_rst", 11);
    chk("pre_rst_level", level, 5);
    chk("pre_rst_ovf", overflow, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_data", out_data, 0);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    in_data = 18'h00055; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 18'h00055);
    chk("post_rst_level", level, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_fifo.md
ADC_SAMPLE_FIFO -- requirements
Module: adc_sample_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, width of the ADC decimator output word.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4; FIFO depth is 2**DEPTH_LOG2 words.
REQ-003 SHALL have parameter SIGNED_OUT, default 0; 1 converts offset-binary input to two's complement on write.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  decimated ADC sample, offset binary.
REQ-007 SHALL have port in_valid  input  1  one-cycle strobe per sample; no backpressure upstream.
REQ-008 SHALL have port out_data  output  DATA_WIDTH  head-of-FIFO sample.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid sample.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid&&out_ready.
REQ-011 SHALL have port level  output  DEPTH_LOG2+1  current stored word count, 0..2**DEPTH_LOG2.
REQ-012 SHALL have port overflow  output  1  sticky flag, a sample was dropped.
REQ-013 SHALL have port overflow_clr  input  1  synchronous clear of overflow.

Function
REQ-014 SHALL push in_data when in_valid=1 and (level<DEPTH or a pop occurs the same cycle).
REQ-015 SHALL drop the incoming sample (drop-newest) when in_valid=1, level=DEPTH and no pop that cycle; stored contents unchanged.
REQ-016 SHALL set overflow on the cycle after a drop; overflow stays 1 until overflow_clr=1.
REQ-017 SHALL give set priority over overflow_clr when a drop and a clear coincide.
REQ-018 SHALL pop the head when out_valid=1 and out_ready=1.
REQ-019 SHALL assert out_valid exactly when level>0, registered; a push into an empty FIFO at edge N gives out_valid=1 and out_data=that sample after edge N.
REQ-020 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL update level each cycle: +1 push only, -1 pop only, unchanged for push+pop or neither.
REQ-022 SHALL accept simultaneous push and pop when empty as a push only (pop requires out_valid=1).
REQ-023 SHALL use DEPTH_LOG2-bit read/write pointers wrapping from DEPTH-1 to 0 with no gap or skipped entry.
REQ-024 SHALL, when SIGNED_OUT=1, invert in_data MSB on write (0x20000 -> 0x00000, 0x00000 -> 0x20000 for width 18); when 0, store unmodified.
REQ-025 SHALL ignore out_ready while out_valid=0.

Reset
REQ-026 SHALL, while rst_n=0, force level=0, out_valid=0, out_data=0, overflow=0, pointers=0, independent of clk.
REQ-027 SHALL discard all stored samples on reset mid-operation; first post-reset push behaves as into empty FIFO.
REQ-028 SHALL release reset synchronously with respect to clk; first push accepted on the first edge with rst_n=1.

Structure
REQ-029 SHALL take the DATA_WIDTH default and the offset-to-signed conversion function from shared package sigma_delta_pkg, shared with the ADC harness.
REQ-030 SHALL place storage in sub-module sample_fifo_mem (one write port, one read port, no reset on array); pointers, level, flags stay in adc_sample_fifo.

Verification
REQ-031 SHALL cover: reset, push 0x00001 while out_ready=0 -> out_valid=1 and out_data=0x00001 one edge later, level=1.
REQ-032 SHALL cover: push 16 samples 1..16 with out_ready=0, then 17th (value 17) -> level=16, overflow=1, drained sequence exactly 1..16.
REQ-033 SHALL cover: FIFO full, push and pop same cycle -> level stays 16, overflow stays 0, new sample appears last in drain order.
REQ-034 SHALL cover: 40 push/pop cycles with random out_ready -> pointer wrap, output order matches input order, no loss.
REQ-035 SHALL cover: SIGNED_OUT=1, push 0x20000, 0x3FFFF, 0x00000 -> out_data 0x00000, 0x1FFFF, 0x20000.
REQ-036 SHALL cover: rst_n pulsed low with level=5 and overflow=1 -> level=0, out_valid=0, overflow=0 immediately, before next clk edge.
